// File: rtl/dma_mem_responder.sv
// rtl/dma_mem_responder.sv - line-addressed memory answering the decompressor DMA read/write channels
// Read and write FSMs run independently; a backdoor port preloads and inspects lines.
module dma_mem_responder #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int MEM_DEPTH_LOG2     = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              dma_rd_req,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     dma_rd_addr,
  input  logic [7:0]                        dma_rd_len,
  output logic                              dma_rd_req_ack,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     dma_rd_data,
  output logic                              dma_rd_data_valid,
  input  logic                              dma_rd_data_taken,
  output logic                              dma_rd_rlast,
  input  logic                              dma_wr_req,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     dma_wr_addr,
  input  logic [7:0]                        dma_wr_len,
  output logic                              dma_wr_req_ack,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     dma_wr_data,
  input  logic                              dma_wr_wvalid,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   dma_wr_data_strobe,
  output logic                              dma_wr_ready,
  input  logic                              dma_wr_wlast,
  output logic                              dma_wr_done,
  input  logic                              dma_wr_bready,
  input  logic                              bd_we,
  input  logic [MEM_DEPTH_LOG2-1:0]         bd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     bd_wdata,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     bd_rdata,
  output logic                              proto_err
);

  localparam int B          = C_M_AXI_DATA_WIDTH / 8;
  localparam int LINE_SHIFT = $clog2(B);
  localparam int DEPTH      = 1 << MEM_DEPTH_LOG2;
  localparam int DW         = C_M_AXI_DATA_WIDTH;
  localparam int DL         = MEM_DEPTH_LOG2;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  logic [DW-1:0] mem [DEPTH];

  rd_state_t     rd_state, rd_state_n;
  logic [DL-1:0] rd_ptr, rd_ptr_n, rd_ptr_inc;
  logic [8:0]    rd_rem, rd_rem_n;
  logic          rd_ack_n, rd_valid_n, rd_last_n;
  logic [DW-1:0] rd_data_n;

  wr_state_t     wr_state, wr_state_n;
  logic [DL-1:0] wr_ptr, wr_ptr_n;
  logic [8:0]    wr_rem, wr_rem_n;
  logic          wr_ack_n, wr_ready_n, wr_done_n, proto_err_n;
  logic          wr_beat, wr_end;

  // Only the line-index bits of the byte address select memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dma_rd_addr[C_M_AXI_ADDR_WIDTH-1:LINE_SHIFT+DL], dma_rd_addr[LINE_SHIFT-1:0],
                              dma_wr_addr[C_M_AXI_ADDR_WIDTH-1:LINE_SHIFT+DL], dma_wr_addr[LINE_SHIFT-1:0]};

  assign bd_rdata   = mem[bd_addr];
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign wr_beat    = (wr_state == W_DATA) && dma_wr_ready && dma_wr_wvalid;
  assign wr_end     = dma_wr_wlast || (wr_rem == 9'd1);

  // Backdoor first, DMA strobed bytes second: on a same-line collision DMA owns its strobed bytes.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (wr_beat) begin
      for (int i = 0; i < B; i++) begin
        if (dma_wr_data_strobe[i]) mem[wr_ptr][8*i +: 8] <= dma_wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_state_n = rd_state;
    rd_ptr_n   = rd_ptr;
    rd_rem_n   = rd_rem;
    rd_ack_n   = 1'b0;
    rd_data_n  = dma_rd_data;
    rd_valid_n = dma_rd_data_valid;
    rd_last_n  = dma_rd_rlast;
    case (rd_state)
      R_IDLE: begin
        if (dma_rd_req) begin
          rd_ack_n   = 1'b1;
          rd_ptr_n   = dma_rd_addr[LINE_SHIFT +: DL];
          rd_rem_n   = {1'b0, dma_rd_len} + 9'd1;
          rd_state_n = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_data_n  = mem[rd_ptr];
        rd_valid_n = 1'b1;
        rd_last_n  = (rd_rem == 9'd1);
        rd_state_n = R_BURST;
      end
      R_BURST: begin
        if (dma_rd_data_valid && dma_rd_data_taken) begin
          if (dma_rd_rlast) begin
            rd_valid_n = 1'b0;
            rd_last_n  = 1'b0;
            rd_state_n = R_IDLE;
          end else begin
            rd_ptr_n  = rd_ptr_inc;
            rd_data_n = mem[rd_ptr_inc];
            rd_rem_n  = rd_rem - 9'd1;
            rd_last_n = (rd_rem == 9'd2);
          end
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state          <= R_IDLE;
      rd_ptr            <= '0;
      rd_rem            <= '0;
      dma_rd_req_ack    <= 1'b0;
      dma_rd_data       <= '0;
      dma_rd_data_valid <= 1'b0;
      dma_rd_rlast      <= 1'b0;
    end else begin
      rd_state          <= rd_state_n;
      rd_ptr            <= rd_ptr_n;
      rd_rem            <= rd_rem_n;
      dma_rd_req_ack    <= rd_ack_n;
      dma_rd_data       <= rd_data_n;
      dma_rd_data_valid <= rd_valid_n;
      dma_rd_rlast      <= rd_last_n;
    end
  end

  always_comb begin
    wr_state_n  = wr_state;
    wr_ptr_n    = wr_ptr;
    wr_rem_n    = wr_rem;
    wr_ack_n    = 1'b0;
    wr_ready_n  = dma_wr_ready;
    wr_done_n   = dma_wr_done;
    proto_err_n = proto_err;
    case (wr_state)
      W_IDLE: begin
        if (dma_wr_req) begin
          wr_ack_n   = 1'b1;
          wr_ready_n = 1'b1;
          wr_ptr_n   = dma_wr_addr[LINE_SHIFT +: DL];
          wr_rem_n   = {1'b0, dma_wr_len} + 9'd1;
          wr_state_n = W_DATA;
        end
      end
      W_DATA: begin
        if (wr_beat) begin
          wr_ptr_n = wr_ptr + 1'b1;
          wr_rem_n = wr_rem - 9'd1;
          if (wr_end) begin
            wr_ready_n  = 1'b0;
            wr_done_n   = 1'b1;
            wr_state_n  = W_RESP;
            // Early wlast or a missing one on the counted last beat both flag an error.
            proto_err_n = proto_err | (dma_wr_wlast != (wr_rem == 9'd1));
          end
        end
      end
      W_RESP: begin
        if (dma_wr_bready) begin
          wr_done_n  = 1'b0;
          wr_state_n = W_IDLE;
        end
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state       <= W_IDLE;
      wr_ptr         <= '0;
      wr_rem         <= '0;
      dma_wr_req_ack <= 1'b0;
      dma_wr_ready   <= 1'b0;
      dma_wr_done    <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      wr_state       <= wr_state_n;
      wr_ptr         <= wr_ptr_n;
      wr_rem         <= wr_rem_n;
      dma_wr_req_ack <= wr_ack_n;
      dma_wr_ready   <= wr_ready_n;
      dma_wr_done    <= wr_done_n;
      proto_err      <= proto_err_n;
    end
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
// tb/tb_dma_mem_responder.sv - scoreboard bench with randomized DMA traffic and a line-memory reference model
module tb_dma_mem_responder;
  localparam int AW = 64, DW = 512, DL = 10, B = DW / 8, DEPTH = 1 << DL;

  logic clk = 1'b0, rst_n = 1'b0;
  logic dma_rd_req = 0, dma_rd_data_taken = 0, dma_rd_req_ack, dma_rd_data_valid, dma_rd_rlast;
  logic [AW-1:0] dma_rd_addr = '0, dma_wr_addr = '0;
  logic [7:0] dma_rd_len = '0, dma_wr_len = '0;
  logic [DW-1:0] dma_rd_data, dma_wr_data = '0, bd_wdata = '0, bd_rdata;
  logic dma_wr_req = 0, dma_wr_req_ack, dma_wr_wvalid = 0, dma_wr_ready, dma_wr_wlast = 0;
  logic dma_wr_done, dma_wr_bready = 0, bd_we = 0, proto_err;
  logic [B-1:0] dma_wr_data_strobe = '0;
  logic [DL-1:0] bd_addr = '0;

  dma_mem_responder #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .MEM_DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .dma_rd_req(dma_rd_req), .dma_rd_addr(dma_rd_addr), .dma_rd_len(dma_rd_len),
    .dma_rd_req_ack(dma_rd_req_ack), .dma_rd_data(dma_rd_data), .dma_rd_data_valid(dma_rd_data_valid),
    .dma_rd_data_taken(dma_rd_data_taken), .dma_rd_rlast(dma_rd_rlast),
    .dma_wr_req(dma_wr_req), .dma_wr_addr(dma_wr_addr), .dma_wr_len(dma_wr_len),
    .dma_wr_req_ack(dma_wr_req_ack), .dma_wr_data(dma_wr_data), .dma_wr_wvalid(dma_wr_wvalid),
    .dma_wr_data_strobe(dma_wr_data_strobe), .dma_wr_ready(dma_wr_ready), .dma_wr_wlast(dma_wr_wlast),
    .dma_wr_done(dma_wr_done), .dma_wr_bready(dma_wr_bready),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .proto_err(proto_err)
  );

  initial forever #5 clk = ~clk;

  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] exp_d [$];
  logic          exp_l [$];
  int vectors = 0, errors = 0;
  int tmode = 0;
  logic exp_perr = 1'b0;
  int cyc;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h need %h", name, act, req);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b need %b", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic int line_of(input logic [AW-1:0] addr);
    return int'((addr / B) % DEPTH);
  endfunction

  task automatic bd_write(input int line, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = DL'(line); bd_wdata = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    mdl[line] = d;
  endtask

  task automatic bd_check(input int line);
    bd_addr = DL'(line);
    #1;
    chk("bd_rdata", bd_rdata, mdl[line]);
  endtask

  task automatic rd_issue(input logic [AW-1:0] addr, input int len);
    int line = line_of(addr);
    for (int k = 0; k <= len; k++) begin
      exp_d.push_back(mdl[(line + k) % DEPTH]);
      exp_l.push_back(k == len);
    end
    dma_rd_req = 1'b1; dma_rd_addr = addr; dma_rd_len = 8'(len);
    @(posedge clk); #1;
    dma_rd_req = 1'b0;
    chkb("rd_ack", dma_rd_req_ack, 1'b1);
    chkb("rd_valid_early", dma_rd_data_valid, 1'b0);
    @(posedge clk); #1;
    chkb("rd_ack_pulse", dma_rd_req_ack, 1'b0);
    chkb("rd_first_valid", dma_rd_data_valid, 1'b1);
  endtask

  task automatic rd_wait(output int n);
    n = 0;
    while ((exp_d.size() != 0 || dma_rd_data_valid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chkb("rd_done_in_time", n < 3000, 1'b1);
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input int len, input int wlast_at,
                          input bit collide, input bit dir_strb);
    int line, k;
    bit fin, v;
    logic [DW-1:0] d, bdw;
    logic [B-1:0] s;
    line = line_of(addr);
    bdw = '0;
    dma_wr_req = 1'b1; dma_wr_addr = addr; dma_wr_len = 8'(len);
    @(posedge clk); #1;
    dma_wr_req = 1'b0;
    chkb("wr_ack", dma_wr_req_ack, 1'b1);
    k = 0; fin = 0;
    while (!fin) begin
      v = dir_strb || ($urandom_range(0, 3) != 0);
      d = rand_line();
      if (dir_strb) begin
        s = '1;
        if (k == 0) begin s = '0; s[7:0] = 8'hFF; end
      end else begin
        s = {$urandom, $urandom};
      end
      dma_wr_wvalid = v; dma_wr_data = d; dma_wr_data_strobe = s;
      dma_wr_wlast = v && (k == wlast_at);
      if (v && collide && k == 0) begin
        bdw = rand_line();
        bd_we = 1'b1; bd_addr = DL'(line); bd_wdata = bdw;
      end
      if (v) chkb("wr_ready", dma_wr_ready, 1'b1);
      @(posedge clk); #1;
      bd_we = 1'b0;
      if (v) begin
        int cur = (line + k) % DEPTH;
        if (collide && k == 0) mdl[cur] = bdw;
        for (int i = 0; i < B; i++) if (s[i]) mdl[cur][8*i +: 8] = d[8*i +: 8];
        fin = (k == wlast_at) || (k == len);
        k++;
      end
    end
    dma_wr_wvalid = 1'b0; dma_wr_wlast = 1'b0;
    if (wlast_at != len) exp_perr = 1'b1;
    chkb("wr_done_rise", dma_wr_done, 1'b1);
    chkb("wr_ready_drop", dma_wr_ready, 1'b0);
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
      chkb("wr_done_hold", dma_wr_done, 1'b1);
    end
    dma_wr_bready = 1'b1;
    @(posedge clk); #1;
    dma_wr_bready = 1'b0;
    chkb("wr_done_clr", dma_wr_done, 1'b0);
    chkb("proto_err", proto_err, exp_perr);
    for (int j = 0; j < k; j++) bd_check((line + j) % DEPTH);
  endtask

  initial begin
    dma_rd_data_taken = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tmode)
        0: dma_rd_data_taken = 1'b1;
        1: dma_rd_data_taken = ~dma_rd_data_taken;
        default: dma_rd_data_taken = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor: pops expected beats on each handshake and checks stalled beats stay put.
  initial begin
    logic hv, hl;
    logic [DW-1:0] hd;
    hv = 0; hl = 0; hd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hv = 0;
        continue;
      end
      if (hv) begin
        chkb("rd_hold_valid", dma_rd_data_valid, 1'b1);
        chk("rd_hold_data", dma_rd_data, hd);
        chkb("rd_hold_last", dma_rd_rlast, hl);
      end
      if (dma_rd_data_valid && dma_rd_data_taken) begin
        chkb("rd_beat_expected", exp_d.size() != 0, 1'b1);
        if (exp_d.size() != 0) begin
          chk("rd_data", dma_rd_data, exp_d.pop_front());
          chkb("rd_last", dma_rd_rlast, exp_l.pop_front());
        end
      end
      hv = dma_rd_data_valid && !dma_rd_data_taken;
      hd = dma_rd_data;
      hl = dma_rd_rlast;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish need finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_rd_ack", dma_rd_req_ack, 1'b0);
    chkb("rst_rd_valid", dma_rd_data_valid, 1'b0);
    chkb("rst_rd_rlast", dma_rd_rlast, 1'b0);
    chk("rst_rd_data", dma_rd_data, '0);
    chkb("rst_wr_ack", dma_wr_req_ack, 1'b0);
    chkb("rst_wr_ready", dma_wr_ready, 1'b0);
    chkb("rst_wr_done", dma_wr_done, 1'b0);
    chkb("rst_proto_err", proto_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int l = 0; l < DEPTH; l++) bd_write(l, rand_line());
    for (int l = 0; l < 4; l++) bd_check(l);

    tmode = 0;
    @(posedge clk); #1;
    rd_issue(64'h0, 3);
    rd_wait(cyc);
    chk("rd_rate", DW'(cyc), DW'(4));

    tmode = 1;
    rd_issue(64'h0, 3);
    dma_rd_req = 1'b1;
    @(posedge clk); #1;
    dma_rd_req = 1'b0;
    chkb("rd_busy_no_ack", dma_rd_req_ack, 1'b0);
    rd_wait(cyc);

    tmode = 0;
    wr_burst(64'h40, 1, 1, 0, 1);
    rd_issue(64'h40, 1);
    rd_wait(cyc);

    rd_issue(64'((DEPTH - 1) * B), 1);
    rd_wait(cyc);

    for (int it = 0; it < 24; it++) begin
      logic [AW-1:0] a;
      int len;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        tmode = $urandom_range(0, 2);
        rd_issue(a, $urandom_range(0, 15));
        rd_wait(cyc);
      end else begin
        len = $urandom_range(0, 7);
        wr_burst(a, len, len, $urandom_range(0, 3) == 0, 0);
      end
    end

    tmode = 2;
    rd_issue(64'(1000 * B), 255);
    rd_wait(cyc);
    tmode = 0;

    wr_burst(64'h1000, 3, 1, 0, 0);
    wr_burst(64'h2000, 2, 2, 0, 0);
    wr_burst(64'h3000, 1, 5, 0, 0);

    @(posedge clk); #1;
    rd_issue(64'h0, 7);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chkb("abort_rd_valid", dma_rd_data_valid, 1'b0);
    chkb("abort_rd_rlast", dma_rd_rlast, 1'b0);
    chkb("abort_rd_ack", dma_rd_req_ack, 1'b0);
    chkb("abort_proto_err", proto_err, 1'b0);
    exp_d.delete();
    exp_l.delete();
    exp_perr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chkb("post_rst_valid", dma_rd_data_valid, 1'b0);
    rd_issue(64'h0, 3);
    rd_wait(cyc);
    chk("rd_rate_after_rst", DW'(cyc), DW'(4));
    wr_burst(64'h80, 2, 2, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rd_leftover", DW'(exp_d.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
